uart_rx_unit: RTL and testbench

Serial receiver for the team's UART. It is the counterpart of the existing Tx unit and uses the same baud_rate and parity_type encodings. The line is oversampled at 16x the baud rate; the block detects the start bit, deserialises 8 data bits LSB-first, and checks the optional parity bit and the stop bit. Received data and error flags are presented with a one-cycle done pulse.

---
 rtl/uart_rx_unit_if.sv | 24 ++
 rtl/uart_rx_unit.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_unit.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_unit_if.sv
// uart_rx_unit_if: serial line, frame settings and received-frame results
// for the UART receiver.
interface uart_rx_unit_if;
  logic       data_rx;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       parity_error;
  logic       stop_error;
  logic       active_flag;
  logic       done_flag;

  modport master (
    output data_rx, baud_rate, parity_type,
    input  data_out, parity_error, stop_error,
    input  active_flag, done_flag
  );

  modport slave (
    input  data_rx, baud_rate, parity_type,
    output data_out, parity_error, stop_error,
    output active_flag, done_flag
  );
endinterface

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: oversampled UART receiver, 8N1 with optional odd/even parity.
// Define RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx_unit #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input logic           clock,
  input logic           reset,
  uart_rx_unit_if.slave rx
);
  localparam int D0 = CLK_FREQ / (2400 * OVERSAMPLE);
  localparam int D1 = CLK_FREQ / (4800 * OVERSAMPLE);
  localparam int D2 = CLK_FREQ / (9600 * OVERSAMPLE);
  localparam int D3 = CLK_FREQ / (19200 * OVERSAMPLE);
  localparam int TW = $clog2(D0 + 1);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE
  } state_t;

  state_t        state;
  logic          sync1, sync2, line_q;
  logic [1:0]    baud_q, par_q;
  logic [TW-1:0] tick_cnt, div_m1;
  logic [CW-1:0] os_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_flag;
  logic          tick, start_edge, parity_on;
  logic          sample_now, sample_bit;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= rx.data_rx;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  always_comb begin
    unique case (baud_q)
      2'b00: div_m1 = TW'(D0 - 1);
      2'b01: div_m1 = TW'(D1 - 1);
      2'b10: div_m1 = TW'(D2 - 1);
      2'b11: div_m1 = TW'(D3 - 1);
    endcase
  end

  assign tick       = (tick_cnt == div_m1);
  assign start_edge = (state == IDLE) && line_q && !sync2;
  assign parity_on  = (par_q == 2'b01) || (par_q == 2'b10);

  // Both counters restart on the start edge so mid-bit lands mid-bit.
  always_ff @(posedge clock) begin
    if (reset || start_edge) begin
      tick_cnt <= '0;
      os_cnt   <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      os_cnt   <= (os_cnt == LAST) ? '0 : os_cnt + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] MID_LO = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID_HI = CW'(OVERSAMPLE / 2 + 1);
  logic [1:0] votes;

  always_ff @(posedge clock) begin
    if (reset) begin
      votes <= 2'b11;
    end else if (tick && os_cnt == MID_LO) begin
      votes[0] <= sync2;
    end else if (tick && os_cnt == MID) begin
      votes[1] <= sync2;
    end
  end

  assign sample_now = tick && (os_cnt == MID_HI);
  assign sample_bit = (votes[0] & votes[1]) |
                      (sync2 & (votes[0] | votes[1]));
`else
  assign sample_now = tick && (os_cnt == MID);
  assign sample_bit = sync2;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      baud_q       <= '0;
      par_q        <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_flag     <= 1'b0;
      rx.data_out     <= '0;
      rx.parity_error <= 1'b0;
      rx.stop_error   <= 1'b0;
      rx.active_flag  <= 1'b0;
      rx.done_flag    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state          <= START;
            baud_q         <= rx.baud_rate;
            par_q          <= rx.parity_type;
            rx.active_flag <= 1'b1;
          end
        end
        START: begin
          if (sample_now) begin
            if (sample_bit) begin
              state          <= IDLE;
              rx.active_flag <= 1'b0;
            end else begin
              state    <= DATA;
              bit_cnt  <= '0;
              par_flag <= 1'b0;
            end
          end
        end
        DATA: begin
          if (sample_now) begin
            shift   <= {sample_bit, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= parity_on ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (sample_now) begin
            par_flag <= sample_bit !=
                        ((par_q == 2'b01) ? ~^shift : ^shift);
            state    <= STOP;
          end
        end
        STOP: begin
          // Leave half-way through the stop bit to re-arm early.
          if (sample_now) begin
            state           <= DONE;
            rx.data_out     <= shift;
            rx.parity_error <= par_flag;
            rx.stop_error   <= ~sample_bit;
            rx.active_flag  <= 1'b0;
            rx.done_flag    <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          rx.done_flag <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: randomized frames on the serial line, results checked
// against a frame-level model of parity and stop-bit rules.
module tb_uart_rx_unit;
  localparam int CF = 1_843_200;

  logic clock = 1'b0;
  logic reset = 1'b1;
  uart_rx_unit_if u_if ();

  uart_rx_unit #(
    .CLK_FREQ(CF),
    .OVERSAMPLE(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx(u_if)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int act_cnt = 0;
  logic [7:0] cap_data;
  logic cap_pe, cap_se, cap_act;

  always @(posedge clock) begin
    #1;
    if (u_if.done_flag === 1'b1) begin
      done_cnt++;
      cap_data = u_if.data_out;
      cap_pe   = u_if.parity_error;
      cap_se   = u_if.stop_error;
      cap_act  = u_if.active_flag;
    end
    if (u_if.active_flag === 1'b1) act_cnt++;
  end

  initial begin
    #900_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  function automatic int bit_clks(input logic [1:0] b);
    return (CF / ((2400 << b) * 16)) * 16;
  endfunction

  function automatic int ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  // Parity bit a correct transmitter would send.
  function automatic logic good_pbit(input logic [7:0] d,
                                     input logic [1:0] pm);
    if (pm == 2'b01) return (ones(d) % 2) == 0;
    return (ones(d) % 2) == 1;
  endfunction

  function automatic logic model_perr(input logic [7:0] d,
                                      input logic [1:0] pm,
                                      input logic pb);
    int total = ones(d) + int'(pb);
    if (pm == 2'b01) return (total % 2) == 0;
    if (pm == 2'b10) return (total % 2) == 1;
    return 1'b0;
  endfunction

  task automatic drive_level(input logic v, input int n);
    @(negedge clock);
    u_if.data_rx = v;
    repeat (n - 1) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm,
                            input logic pb, input logic sb, input int n);
    drive_level(1'b0, n);
    for (int i = 0; i < 8; i++) drive_level(d[i], n);
    if (pm == 2'b01 || pm == 2'b10) drive_level(pb, n);
    drive_level(sb, n);
  endtask

  task automatic test_reset;
    u_if.data_rx = 1'b1;
    u_if.baud_rate = 2'b10;
    u_if.parity_type = 2'b00;
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if ({u_if.data_out, u_if.parity_error, u_if.stop_error,
         u_if.active_flag, u_if.done_flag} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outs: got %h/%b%b%b%b want 00/0000",
               u_if.data_out, u_if.parity_error, u_if.stop_error,
               u_if.active_flag, u_if.done_flag);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    checks++;
    if (done_cnt != 0 || u_if.active_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got done=%0d act=%b want 0 0",
               done_cnt, u_if.active_flag);
    end
  endtask

  task automatic test_none_a5;
    int d0 = done_cnt;
    u_if.baud_rate = 2'b10;
    u_if.parity_type = 2'b00;
    act_cnt = 0;
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 192);
    drive_level(1'b1, 10);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL t1_done: got %0d want 1", done_cnt - d0);
    end
    checks++;
    if ({cap_data, cap_pe, cap_se, cap_act} !== {8'hA5, 3'b000}) begin
      errors++;
      $display("FAIL t1_frame: got %h %b%b%b want a5 000",
               cap_data, cap_pe, cap_se, cap_act);
    end
    checks++;
    if (act_cnt < 9 * 192 || act_cnt > 10 * 192) begin
      errors++;
      $display("FAIL t1_active_len: got %0d want 1728..1920", act_cnt);
    end
    checks++;
    if (u_if.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL t1_hold: got %h want a5", u_if.data_out);
    end
  endtask

  task automatic test_even_parity;
    for (int k = 0; k < 2; k++) begin
      int d0 = done_cnt;
      logic pb = (k == 0);
      logic exp_pe = model_perr(8'h37, 2'b10, pb);
      u_if.parity_type = 2'b10;
      send_frame(8'h37, 2'b10, pb, 1'b1, 192);
      drive_level(1'b1, 10);
      checks++;
      if (done_cnt - d0 != 1 || cap_data !== 8'h37 ||
          cap_pe !== exp_pe || cap_se !== 1'b0) begin
        errors++;
        $display("FAIL t2_even%0d: got n=%0d %h pe=%b se=%b want 1 37 %b 0",
                 k, done_cnt - d0, cap_data, cap_pe, cap_se, exp_pe);
      end
    end
  endtask

  task automatic test_odd_stop;
    int d0 = done_cnt;
    logic [7:0] d = 8'($urandom);
    u_if.parity_type = 2'b01;
    send_frame(8'h00, 2'b01, 1'b1, 1'b0, 192);
    checks++;
    if (done_cnt - d0 != 1 || cap_data !== 8'h00 ||
        cap_pe !== 1'b0 || cap_se !== 1'b1) begin
      errors++;
      $display("FAIL t3_frame: got n=%0d %h pe=%b se=%b want 1 00 0 1",
               done_cnt - d0, cap_data, cap_pe, cap_se);
    end
    d0 = done_cnt;
    drive_level(1'b0, 3 * 192);
    checks++;
    if (done_cnt != d0 || u_if.active_flag !== 1'b0) begin
      errors++;
      $display("FAIL t3_held_low: got n=%0d act=%b want 0 0",
               done_cnt - d0, u_if.active_flag);
    end
    drive_level(1'b1, 192);
    send_frame(d, 2'b01, good_pbit(d, 2'b01), 1'b1, 192);
    drive_level(1'b1, 10);
    checks++;
    if (done_cnt - d0 != 1 || cap_data !== d ||
        cap_pe !== 1'b0 || cap_se !== 1'b0) begin
      errors++;
      $display("FAIL t3_recover: got n=%0d %h %b%b want 1 %h 00",
               done_cnt - d0, cap_data, cap_pe, cap_se, d);
    end
  endtask

  task automatic test_glitch;
    int d0 = done_cnt;
    logic [7:0] prev = cap_data;
    act_cnt = 0;
    drive_level(1'b0, 40);
    drive_level(1'b1, 192);
    checks++;
    if (act_cnt == 0 || act_cnt > 192 || u_if.active_flag !== 1'b0) begin
      errors++;
      $display("FAIL t4_active: got cycles=%0d act=%b want 1..192 0",
               act_cnt, u_if.active_flag);
    end
    checks++;
    if (done_cnt != d0 || u_if.data_out !== prev) begin
      errors++;
      $display("FAIL t4_nodone: got n=%0d %h want 0 %h",
               done_cnt - d0, u_if.data_out, prev);
    end
  endtask

  task automatic test_reset_mid;
    int d0 = done_cnt;
    logic [7:0] d = {4'hF, 4'($urandom)};
    u_if.parity_type = 2'b00;
    fork
      send_frame(d, 2'b00, 1'b0, 1'b1, 192);
      begin
        repeat (5 * 192 + 96) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({u_if.data_out, u_if.parity_error, u_if.stop_error,
             u_if.active_flag, u_if.done_flag} !== 12'h000) begin
          errors++;
          $display("FAIL t5_reset: got %h %b%b%b%b want 00 0000",
                   u_if.data_out, u_if.parity_error, u_if.stop_error,
                   u_if.active_flag, u_if.done_flag);
        end
        @(negedge clock);
        reset = 1'b0;
      end
    join
    drive_level(1'b1, 10);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL t5_nodone: got %0d want 0", done_cnt - d0);
    end
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 192);
    drive_level(1'b1, 10);
    checks++;
    if (done_cnt - d0 != 1 || cap_data !== 8'h5A ||
        cap_pe !== 1'b0 || cap_se !== 1'b0) begin
      errors++;
      $display("FAIL t5_after: got n=%0d %h %b%b want 1 5a 00",
               done_cnt - d0, cap_data, cap_pe, cap_se);
    end
  endtask

  task automatic test_baud_latch;
    int d0 = done_cnt;
    logic [7:0] d = 8'($urandom);
    u_if.baud_rate = 2'b00;
    u_if.parity_type = 2'b00;
    fork
      send_frame(8'hFF, 2'b00, 1'b0, 1'b1, bit_clks(2'b00));
      begin
        repeat (3 * bit_clks(2'b00)) @(negedge clock);
        u_if.baud_rate = 2'b11;
      end
    join
    drive_level(1'b1, 10);
    checks++;
    if (done_cnt - d0 != 1 || cap_data !== 8'hFF || cap_se !== 1'b0) begin
      errors++;
      $display("FAIL t6_slow: got n=%0d %h se=%b want 1 ff 0",
               done_cnt - d0, cap_data, cap_se);
    end
    send_frame(d, 2'b00, 1'b0, 1'b1, bit_clks(2'b11));
    drive_level(1'b1, 10);
    checks++;
    if (done_cnt - d0 != 2 || cap_data !== d || cap_se !== 1'b0) begin
      errors++;
      $display("FAIL t6_fast: got n=%0d %h se=%b want 2 %h 0",
               done_cnt - d0, cap_data, cap_se, d);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 10; k++) begin
      int d0 = done_cnt;
      logic [7:0] d = 8'($urandom);
      logic [1:0] b = 2'($urandom_range(1, 3));
      logic [1:0] pm = 2'($urandom);
      logic pb = good_pbit(d, pm) ^ ($urandom_range(0, 3) == 0);
      logic sb = $urandom_range(0, 4) != 0;
      int n = bit_clks(b);
      u_if.baud_rate = b;
      u_if.parity_type = pm;
      fork
        send_frame(d, pm, pb, sb, n);
        begin
          repeat (3 * n) @(negedge clock);
          u_if.baud_rate = 2'($urandom);
          u_if.parity_type = 2'($urandom);
        end
      join
      checks++;
      if (done_cnt - d0 != 1 || cap_data !== d || cap_act !== 1'b0 ||
          cap_pe !== model_perr(d, pm, pb) || cap_se !== !sb) begin
        errors++;
        $display("FAIL b2b_%0d: got n=%0d %h pe=%b se=%b act=%b want 1 %h %b %b 0",
                 k, done_cnt - d0, cap_data, cap_pe, cap_se, cap_act,
                 d, model_perr(d, pm, pb), !sb);
      end
      if (!sb) drive_level(1'b1, n);
    end
  endtask

  initial begin
    test_reset();
    test_none_a5();
    test_even_parity();
    test_odd_stop();
    test_glitch();
    test_reset_mid();
    test_baud_latch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
